rggen_axi4lite_bridge: RTL and testbench
========================================

// Module: rggen_axi4lite_bridge
// PURPOSE
//  Upstream neighbour of the common register adapter: converts an AXI4-Lite slave port into the rggen_bus_if master side.
//  Accepts one write (AW+W) or one read (AR), issues a single held bus_if request, registers the response, returns it on B/R.
//  Single outstanding transaction. Request is held stable until bus_if.ready; no combinational path from bus_if to AXI outputs.
// PARAMETERS
//  ADDRESS_WIDTH  16             byte address width of AXI and bus_if
//  BUS_WIDTH      32             data width (32 or 64)
//  STROBE_WIDTH   BUS_WIDTH/8    byte strobe width
// PORTS
//  i_clk          in   1             clock
//  i_rst_n        in   1             asynchronous active-low reset
//  i_awvalid      in   1             AW valid
//  o_awready      out  1             AW ready
//  i_awaddr       in   ADDRESS_WIDTH write address
//  i_awprot       in   3             ignored
//  i_wvalid       in   1             W valid
//  o_wready       out  1             W ready
//  i_wdata        in   BUS_WIDTH     write data
//  i_wstrb        in   STROBE_WIDTH  write strobe
//  o_bvalid       out  1             B valid
//  i_bready       in   1             B ready
//  o_bresp        out  2             write response
//  i_arvalid      in   1             AR valid
//  o_arready      out  1             AR ready
//  i_araddr       in   ADDRESS_WIDTH read address
//  i_arprot       in   3             ignored
//  o_rvalid       out  1             R valid
//  i_rready       in   1             R ready
//  o_rdata        out  BUS_WIDTH     read data
//  o_rresp        out  2             read response
//  bus_if         rggen_bus_if.master  valid/access/address/write_data/strobe out; ready/status/read_data in
// BEHAVIOUR
//  Clock i_clk; reset i_rst_n asynchronous, active-low.
//  States: IDLE, BUS, WRESP, RRESP. Reset -> IDLE; all valid/ready outputs 0, request/response registers 0, bresp/rresp 2'b00.
//  IDLE: write pending = i_awvalid && i_wvalid; read pending = i_arvalid. AW and W are always accepted together, never singly.
//   o_awready = o_wready = IDLE && write grant; o_arready = IDLE && read grant (combinational on state/valids).
//   Both pending: write wins (fixed priority) unless the macro below is defined.
//   Accept edge: latch access (RGGEN_WRITE / RGGEN_READ), address, wdata, wstrb (read: strobe '1, write_data '0) -> BUS.
//  BUS: bus_if.valid = 1 with all request fields from registers, stable every cycle until bus_if.ready.
//   Edge with bus_if.ready: capture status and read_data -> WRESP (write) or RRESP (read). Min latency accept->B/R valid: 2 cycles.
//  WRESP: o_bvalid = 1; leave to IDLE on i_bready. RRESP: o_rvalid = 1, o_rdata held; leave to IDLE on i_rready.
//   No new AXI request is accepted in BUS/WRESP/RRESP; all readies 0.
//  Response map: RGGEN_OKAY -> 2'b00, RGGEN_EXOKAY -> 2'b01, RGGEN_SLAVE_ERROR -> 2'b10, RGGEN_DECODE_ERROR -> 2'b11.
//  o_rdata = captured bus_if.read_data for reads only. Write responses do not update o_rdata.
//  bus_if.valid is 0 outside BUS. Back-to-back: next accept occurs in the IDLE cycle after B/R handshake (1 bubble).
//  i_awvalid without i_wvalid (or the reverse): no acceptance. A pending read may be granted meanwhile.
//  Reset asserted mid-transaction: abort, return to IDLE, drop response; downstream ignores the abandoned request.
// CONFIGURATION
//  RGGEN_AXI4LITE_BRIDGE_ROUND_ROBIN_EN defined:
//   A 1-bit priority flag (reset 0 = write first) selects the winner when write and read are both pending.
//   The flag toggles only on a contested grant, so contested requests alternate W,R,W,R.
//  Undefined: fixed write priority; the flag is not built.
// TESTING
//  Write AW=0x0010, WDATA=0xA5A5_0001, WSTRB=4'b0011; bus ready after 2 cycles, OKAY
//   -> bus_if.valid high 3 cycles with stable fields, strobe 4'b0011; BVALID 1 cycle later with BRESP=00.
//  Read AR=0x0020; bus ready same cycle as valid, read_data=0x1234_5678, SLAVE_ERROR
//   -> RVALID 2 cycles after accept, RDATA=0x1234_5678, RRESP=10. Read strobe is '1.
//  AW and AR both valid from cycle 0, W arrives cycle 3 -> read granted first.
//   Write is accepted in the IDLE cycle after the R handshake.
//  Write and read both pending continuously, 4 transactions -> order W,W,W,W in fixed mode; W,R,W,R with ROUND_ROBIN_EN.
//  Hold BREADY low 5 cycles -> BVALID/BRESP stable, all readies 0, bus_if.valid 0 throughout.
//  Assert i_rst_n low in BUS state -> next cycle all outputs at reset values, state IDLE.
//   A fresh write then completes with BRESP=00.

Source files
------------

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen_bus_if master bridge with a single outstanding transaction.
// Define RGGEN_AXI4LITE_BRIDGE_ROUND_ROBIN_EN to alternate write/read priority on contested grants.

package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic [2:0]               i_awprot,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [STROBE_WIDTH-1:0]  i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  input  logic [2:0]               i_arprot,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic [1:0]               o_rresp,
  rggen_bus_if.master              bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    WRESP = 2'b10,
    RRESP = 2'b11
  } state_e;

  state_e                   state_q;
  state_e                   state_next;
  logic                     write_pending;
  logic                     read_pending;
  logic                     write_grant;
  logic                     read_grant;
  logic                     accept_write;
  logic                     accept_read;
  logic                     bus_done;
  rggen_access              access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STROBE_WIDTH-1:0]  strobe_q;
  logic [1:0]               bresp_q;
  logic [1:0]               rresp_q;
  logic [BUS_WIDTH-1:0]     rdata_q;
  logic                     unused_prot;

  assign unused_prot = ^{i_awprot, i_arprot};

  function automatic logic [1:0] to_axi_resp(input rggen_status status);
    case (status)
      RGGEN_OKAY:         return 2'b00;
      RGGEN_EXOKAY:       return 2'b01;
      RGGEN_SLAVE_ERROR:  return 2'b10;
      RGGEN_DECODE_ERROR: return 2'b11;
      default:            return 2'b10;
    endcase
  endfunction

  // A write needs both AW and W present so the two channels are always taken together.
  assign write_pending = i_awvalid && i_wvalid;
  assign read_pending  = i_arvalid;

`ifdef RGGEN_AXI4LITE_BRIDGE_ROUND_ROBIN_EN
  logic read_first_q;
  logic contested;

  assign contested   = (state_q == IDLE) && write_pending && read_pending;
  assign write_grant = write_pending && !(read_pending && read_first_q);
  assign read_grant  = read_pending && !write_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_first_q <= 1'b0;
    end else if (contested) begin
      read_first_q <= ~read_first_q;
    end
  end
`else
  assign write_grant = write_pending;
  assign read_grant  = read_pending && !write_pending;
`endif

  assign accept_write = (state_q == IDLE) && write_grant;
  assign accept_read  = (state_q == IDLE) && read_grant;
  assign bus_done     = (state_q == BUS) && bus_if.ready;

  assign o_awready = accept_write;
  assign o_wready  = accept_write;
  assign o_arready = accept_read;

  assign bus_if.valid      = (state_q == BUS);
  assign bus_if.access     = access_q;
  assign bus_if.address    = address_q;
  assign bus_if.write_data = write_data_q;
  assign bus_if.strobe     = strobe_q;

  assign o_bvalid = (state_q == WRESP);
  assign o_bresp  = bresp_q;
  assign o_rvalid = (state_q == RRESP);
  assign o_rresp  = rresp_q;
  assign o_rdata  = rdata_q;

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (accept_write || accept_read) begin
          state_next = BUS;
        end
      end
      BUS: begin
        if (bus_if.ready) begin
          state_next = (access_q == RGGEN_WRITE) ? WRESP : RRESP;
        end
      end
      WRESP: begin
        if (i_bready) begin
          state_next = IDLE;
        end
      end
      RRESP: begin
        if (i_rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Request fields only change on an accept, which keeps them stable for the whole BUS phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q     <= rggen_access'(2'b00);
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else if (accept_write) begin
      access_q     <= RGGEN_WRITE;
      address_q    <= i_awaddr;
      write_data_q <= i_wdata;
      strobe_q     <= i_wstrb;
    end else if (accept_read) begin
      access_q     <= RGGEN_READ;
      address_q    <= i_araddr;
      write_data_q <= '0;
      strobe_q     <= '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
      rdata_q <= '0;
    end else if (bus_done) begin
      if (access_q == RGGEN_WRITE) begin
        bresp_q <= to_axi_resp(bus_if.status);
      end else begin
        rresp_q <= to_axi_resp(bus_if.status);
        rdata_q <= bus_if.read_data;
      end
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed self-checking bench for rggen_axi4lite_bridge with a delay-programmable bus slave.
// Expected grant order follows RGGEN_AXI4LITE_BRIDGE_ROUND_ROBIN_EN when it is defined.

module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;

  rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus_if ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awprot(3'b000),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arprot(3'b000),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .bus_if(bus_if)
  );

  always #5 clk = ~clk;

  // Bus slave: asserts ready after bus_delay wait cycles of a held request.
  int          bus_delay = 0;
  int          wait_cnt  = 0;
  rggen_status bus_status = RGGEN_OKAY;
  logic [31:0] bus_rdata  = '0;

  assign bus_if.ready     = bus_if.valid && (wait_cnt == bus_delay);
  assign bus_if.status    = bus_status;
  assign bus_if.read_data = bus_rdata;

  always @(posedge clk) begin
    if (!bus_if.valid || bus_if.ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Request monitor: records fields, valid length, stability and completion order.
  logic        in_flight = 1'b0;
  logic [1:0]  cap_access;
  logic [15:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_strobe;
  int          cur_cycles = 0;
  int          last_cycles = 0;
  int          stable_errs = 0;
  logic [1:0]  order_q[$];

  always @(negedge clk) begin
    if (bus_if.valid) begin
      if (!in_flight) begin
        in_flight  = 1'b1;
        cap_access = bus_if.access;
        cap_addr   = bus_if.address;
        cap_wdata  = bus_if.write_data;
        cap_strobe = bus_if.strobe;
        cur_cycles = 1;
      end else begin
        if ({bus_if.access, bus_if.address, bus_if.write_data, bus_if.strobe} !==
            {cap_access, cap_addr, cap_wdata, cap_strobe}) stable_errs++;
        cur_cycles++;
      end
      if (bus_if.ready) begin
        in_flight   = 1'b0;
        last_cycles = cur_cycles;
        order_q.push_back(cap_access);
      end
    end else begin
      in_flight = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic awv, input logic [15:0] awa, input logic wv,
                               input logic [31:0] wd, input logic [3:0] ws, input logic arv,
                               input logic [15:0] ara, input logic br, input logic rr);
    awvalid = awv; awaddr = awa; wvalid = wv; wdata = wd; wstrb = ws;
    arvalid = arv; araddr = ara; bready = br; rready = rr;
    #1;
  endtask

  task automatic waitResponse(input logic want_b, output int lat);
    lat = 1;
    while (!(want_b ? bvalid : rvalid) && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [1:0] exp_order [4];
`ifdef RGGEN_AXI4LITE_BRIDGE_ROUND_ROBIN_EN
    exp_order = '{2'b11, 2'b10, 2'b11, 2'b10};
`else
    exp_order = '{2'b11, 2'b11, 2'b11, 2'b11};
`endif

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checkOutput("rst_awready", awready, 0);
    checkOutput("rst_arready", arready, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_busvalid", bus_if.valid, 0);
    checkOutput("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] write with two wait cycles");
    bus_delay = 2; bus_status = RGGEN_OKAY; bus_rdata = 32'hDEAD_BEEF;
    applyStimulus(1, 16'h0010, 1, 32'hA5A5_0001, 4'b0011, 0, 0, 0, 0);
    checkOutput("wr_awready", awready, 1);
    checkOutput("wr_wready", wready, 1);
    checkOutput("wr_arready", arready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitResponse(1'b1, lat);
    checkOutput("wr_latency", lat, 4);
    checkOutput("wr_valid_cycles", last_cycles, 3);
    checkOutput("wr_access", cap_access, 2'b11);
    checkOutput("wr_addr", cap_addr, 16'h0010);
    checkOutput("wr_wdata", cap_wdata, 32'hA5A5_0001);
    checkOutput("wr_strobe", cap_strobe, 4'b0011);
    checkOutput("wr_bresp", bresp, 2'b00);
    checkOutput("wr_busvalid_off", bus_if.valid, 0);
    checkOutput("wr_rdata_untouched", rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("wr_bvalid_clear", bvalid, 0);

    $display("[TB] read with immediate ready and slave error");
    bus_delay = 0; bus_status = RGGEN_SLAVE_ERROR; bus_rdata = 32'h1234_5678;
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0020, 0, 0);
    checkOutput("rd_arready", arready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitResponse(1'b0, lat);
    checkOutput("rd_latency", lat, 2);
    checkOutput("rd_rdata", rdata, 32'h1234_5678);
    checkOutput("rd_rresp", rresp, 2'b10);
    checkOutput("rd_access", cap_access, 2'b10);
    checkOutput("rd_strobe", cap_strobe, 4'hF);
    checkOutput("rd_wdata_zero", cap_wdata, 0);
    checkOutput("rd_addr", cap_addr, 16'h0020);
    checkOutput("rd_bresp_untouched", bresp, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("rd_rvalid_clear", rvalid, 0);

    $display("[TB] AW and AR together, W late");
    order_q.delete();
    bus_status = RGGEN_EXOKAY; bus_rdata = 32'hCAFE_0000;
    applyStimulus(1, 16'h0030, 0, 32'h0000_0077, 4'hF, 1, 16'h0040, 0, 0);
    checkOutput("mix_arready", arready, 1);
    checkOutput("mix_awready", awready, 0);
    tick();
    applyStimulus(1, 16'h0030, 0, 32'h0000_0077, 4'hF, 0, 0, 0, 0);
    waitResponse(1'b0, lat);
    checkOutput("mix_rdata", rdata, 32'hCAFE_0000);
    checkOutput("mix_rresp", rresp, 2'b01);
    applyStimulus(1, 16'h0030, 1, 32'h0000_0077, 4'hF, 0, 0, 0, 1);
    checkOutput("mix_awready_busy", awready, 0);
    tick();
    applyStimulus(1, 16'h0030, 1, 32'h0000_0077, 4'hF, 0, 0, 0, 0);
    checkOutput("mix_awready_idle", awready, 1);
    checkOutput("mix_wready_idle", wready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitResponse(1'b1, lat);
    checkOutput("mix_bresp", bresp, 2'b01);
    checkOutput("mix_count", order_q.size(), 2);
    checkOutput("mix_first", order_q[0], 2'b10);
    checkOutput("mix_second", order_q[1], 2'b11);
    checkOutput("mix_waddr", cap_addr, 16'h0030);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();

    $display("[TB] contested write and read");
    order_q.delete();
    bus_status = RGGEN_OKAY;
    applyStimulus(1, 16'h0100, 1, 32'h0000_1111, 4'hF, 1, 16'h0200, 1, 1);
    n = 0;
    while (order_q.size() < 4 && n < 80) begin
      tick();
      n++;
    end
    checkOutput("contest_in_time", n < 80, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    n = 0;
    while ((bvalid || rvalid || bus_if.valid) && n < 20) begin
      tick();
      n++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("contest_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("contest_order%0d", i), order_q[i], exp_order[i]);
    end

    $display("[TB] stalled B channel");
    bus_status = RGGEN_DECODE_ERROR;
    applyStimulus(1, 16'h0050, 1, 32'h0000_0050, 4'h1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 16'h0054, 1, 32'h0000_0054, 4'h1, 1, 16'h0058, 0, 0);
    waitResponse(1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_bvalid%0d", i), bvalid, 1);
      checkOutput($sformatf("stall_bresp%0d", i), bresp, 2'b11);
      checkOutput($sformatf("stall_awready%0d", i), awready, 0);
      checkOutput($sformatf("stall_arready%0d", i), arready, 0);
      checkOutput($sformatf("stall_busvalid%0d", i), bus_if.valid, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("stall_bvalid_clear", bvalid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during bus phase");
    bus_delay = 10; bus_status = RGGEN_OKAY;
    applyStimulus(1, 16'h0060, 1, 32'h0000_0060, 4'hF, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("abort_busvalid_before", bus_if.valid, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_busvalid", bus_if.valid, 0);
    checkOutput("abort_bvalid", bvalid, 0);
    checkOutput("abort_bresp", bresp, 2'b00);
    checkOutput("abort_rresp", rresp, 2'b00);
    checkOutput("abort_rdata", rdata, 0);
    checkOutput("abort_awready", awready, 0);
    rst_n = 1'b1;
    tick();
    bus_delay = 1;
    applyStimulus(1, 16'h0070, 1, 32'h0000_0070, 4'hF, 0, 0, 0, 0);
    checkOutput("fresh_awready", awready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitResponse(1'b1, lat);
    checkOutput("fresh_latency", lat, 3);
    checkOutput("fresh_bresp", bresp, 2'b00);
    checkOutput("fresh_addr", cap_addr, 16'h0070);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    checkOutput("request_stability", stable_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
